// File: rtl/ifu_fetchq.sv
// Instruction fetch unit: sequential PC generation, single-outstanding bus
// handshake, QDEPTH-entry {pc, instr} queue toward decode, redirect flush.
module ifu_fetchq #(
  parameter int              XLEN     = 64,
  parameter int              ILEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 'h8000_0000,
  parameter int              QDEPTH   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ifu_valid,
  output logic                      ireq_valid,
  output logic [XLEN-1:0]           ireq_addr,
  input  logic                      iresp_data_ok,
  input  logic [ILEN-1:0]           iresp_data,
  input  logic                      redirect_valid,
  input  logic [XLEN-1:0]           pc_target,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [XLEN-1:0]           out_pc,
  output logic [ILEN-1:0]           out_instr,
  output logic [$clog2(QDEPTH):0]   out_count
);

  localparam int PTRW = $clog2(QDEPTH);
  localparam int CNTW = PTRW + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DROP} state_e;

  state_e          state_q;
  logic [XLEN-1:0] fetchPc_q;
  logic [XLEN-1:0] dropAddr_q;

  logic [XLEN-1:0] memPc_q    [QDEPTH];
  logic [ILEN-1:0] memInstr_q [QDEPTH];
  logic [PTRW-1:0] rdPtr_q, rdPtr_d;
  logic [PTRW-1:0] wrPtr_q, wrPtr_d;
  logic [CNTW-1:0] count_q, count_d;

  logic issue;
  logic push;
  logic pop;

  assign issue      = (state_q == IDLE) & ifu_valid & ~redirect_valid &
                      (count_q < CNTW'(QDEPTH));
  assign ireq_valid = issue | (state_q == BUSY) | (state_q == DROP);
  assign ireq_addr  = (state_q == DROP) ? dropAddr_q : fetchPc_q;

  // A response accepted in IDLE only counts if we actually issued this cycle.
  assign push = iresp_data_ok & ~redirect_valid &
                ((state_q == BUSY) | ((state_q == IDLE) & issue));

  assign out_valid = (count_q != '0) & ~redirect_valid;
  assign pop       = out_valid & out_ready;
  assign out_pc    = memPc_q[rdPtr_q];
  assign out_instr = memInstr_q[rdPtr_q];
  assign out_count = count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      fetchPc_q  <= RESET_PC;
      dropAddr_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (redirect_valid) begin
            fetchPc_q <= pc_target;
          end else if (issue) begin
            if (iresp_data_ok) fetchPc_q <= fetchPc_q + XLEN'(4);
            else               state_q   <= BUSY;
          end
        end
        BUSY: begin
          if (iresp_data_ok) begin
            state_q   <= IDLE;
            fetchPc_q <= redirect_valid ? pc_target : fetchPc_q + XLEN'(4);
          end else if (redirect_valid) begin
            // The bus still owns the old address until its response arrives.
            dropAddr_q <= fetchPc_q;
            fetchPc_q  <= pc_target;
            state_q    <= DROP;
          end
        end
        DROP: begin
          if (redirect_valid) fetchPc_q <= pc_target;
          if (iresp_data_ok)  state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    count_d = count_q;
    if (redirect_valid) begin
      rdPtr_d = '0;
      wrPtr_d = '0;
      count_d = '0;
    end else begin
      if (push) wrPtr_d = wrPtr_q + 1'b1;
      if (pop)  rdPtr_d = rdPtr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        memPc_q[i]    <= '0;
        memInstr_q[i] <= '0;
      end
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      count_q <= count_d;
      if (push) begin
        memPc_q[wrPtr_q]    <= fetchPc_q;
        memInstr_q[wrPtr_q] <= iresp_data;
      end
    end
  end

endmodule

// File: tb/tb_ifu_fetchq.sv
// Directed bench for ifu_fetchq: streaming, full stall, wait states,
// redirect handling and asynchronous reset.
module tb_ifu_fetchq;

  logic        clk;
  logic        rst;
  logic        ifu_valid;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        redirect_valid;
  logic [63:0] pc_target;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic [2:0]  out_count;

  logic busZero;
  logic dataOkMan;

  int checks;
  int failures;

  ifu_fetchq dut (
    .clk            (clk),
    .rst            (rst),
    .ifu_valid      (ifu_valid),
    .ireq_valid     (ireq_valid),
    .ireq_addr      (ireq_addr),
    .iresp_data_ok  (iresp_data_ok),
    .iresp_data     (iresp_data),
    .redirect_valid (redirect_valid),
    .pc_target      (pc_target),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_count      (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus returns the low address bits as the instruction word.
  assign iresp_data_ok = busZero ? ireq_valid : dataOkMan;
  assign iresp_data    = ireq_addr[31:0];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset_stream();
    rst = 1'b1; ifu_valid = 1'b1; busZero = 1'b1; dataOkMan = 1'b0;
    out_ready = 1'b1; redirect_valid = 1'b0; pc_target = '0;
    #2;
    checks++; if (ireq_valid !== 1'b1) begin failures++; $display("[TB] FAIL rst_ireq_valid got=%0b exp=1", ireq_valid); end
    checks++; if (ireq_addr !== 64'h8000_0000) begin failures++; $display("[TB] FAIL rst_ireq_addr got=%h exp=80000000", ireq_addr); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_out_valid got=%0b exp=0", out_valid); end
    checks++; if (out_count !== 3'd0) begin failures++; $display("[TB] FAIL rst_out_count got=%0d exp=0", out_count); end
    checks++; if (out_pc !== 64'h0) begin failures++; $display("[TB] FAIL rst_out_pc got=%h exp=0", out_pc); end
    checks++; if (out_instr !== 32'h0) begin failures++; $display("[TB] FAIL rst_out_instr got=%h exp=0", out_instr); end
    @(posedge clk); #1; rst = 1'b0;
    step();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL stream_valid0 got=%0b exp=1", out_valid); end
    checks++; if (out_pc !== 64'h8000_0000) begin failures++; $display("[TB] FAIL stream_pc0 got=%h exp=80000000", out_pc); end
    step();
    checks++; if (out_pc !== 64'h8000_0004) begin failures++; $display("[TB] FAIL stream_pc1 got=%h exp=80000004", out_pc); end
    checks++; if (out_instr !== 32'h8000_0004) begin failures++; $display("[TB] FAIL stream_instr1 got=%h exp=80000004", out_instr); end
    step();
    checks++; if (out_pc !== 64'h8000_0008) begin failures++; $display("[TB] FAIL stream_pc2 got=%h exp=80000008", out_pc); end
    checks++; if (out_count !== 3'd1) begin failures++; $display("[TB] FAIL stream_count got=%0d exp=1", out_count); end
  endtask

  task automatic test_full_stall();
    out_ready = 1'b0; busZero = 1'b1; ifu_valid = 1'b1;
    doReset();
    repeat (4) step();
    checks++; if (out_count !== 3'd4) begin failures++; $display("[TB] FAIL full_count got=%0d exp=4", out_count); end
    checks++; if (ireq_valid !== 1'b0) begin failures++; $display("[TB] FAIL full_ireq_valid got=%0b exp=0", ireq_valid); end
    step();
    checks++; if (out_count !== 3'd4) begin failures++; $display("[TB] FAIL full_hold_count got=%0d exp=4", out_count); end
    checks++; if (out_pc !== 64'h8000_0000) begin failures++; $display("[TB] FAIL full_head got=%h exp=80000000", out_pc); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    #1;
    checks++; if (out_count !== 3'd3) begin failures++; $display("[TB] FAIL pop_count got=%0d exp=3", out_count); end
    checks++; if (out_pc !== 64'h8000_0004) begin failures++; $display("[TB] FAIL pop_head got=%h exp=80000004", out_pc); end
    checks++; if (ireq_valid !== 1'b1) begin failures++; $display("[TB] FAIL refill_req got=%0b exp=1", ireq_valid); end
    checks++; if (ireq_addr !== 64'h8000_0010) begin failures++; $display("[TB] FAIL refill_addr got=%h exp=80000010", ireq_addr); end
    step();
    checks++; if (out_count !== 3'd4) begin failures++; $display("[TB] FAIL refill_count got=%0d exp=4", out_count); end
    checks++; if (ireq_valid !== 1'b0) begin failures++; $display("[TB] FAIL refill_stop got=%0b exp=0", ireq_valid); end
    step();
    checks++; if (out_count !== 3'd4) begin failures++; $display("[TB] FAIL refill_once got=%0d exp=4", out_count); end
  endtask

  task automatic test_wait_state();
    busZero = 1'b0; dataOkMan = 1'b0; out_ready = 1'b0; ifu_valid = 1'b1;
    doReset();
    checks++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0000) begin failures++; $display("[TB] FAIL ws_issue got=%0b/%h exp=1/80000000", ireq_valid, ireq_addr); end
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0000) begin failures++; $display("[TB] FAIL ws_hold%0d got=%0b/%h exp=1/80000000", i, ireq_valid, ireq_addr); end
    end
    dataOkMan = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL ws_nobypass got=%0b exp=0", out_valid); end
    step();
    dataOkMan = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL ws_valid got=%0b exp=1", out_valid); end
    checks++; if (out_instr !== 32'h8000_0000) begin failures++; $display("[TB] FAIL ws_instr got=%h exp=80000000", out_instr); end
    checks++; if (ireq_addr !== 64'h8000_0004) begin failures++; $display("[TB] FAIL ws_next_addr got=%h exp=80000004", ireq_addr); end
  endtask

  task automatic test_redirect_busy();
    busZero = 1'b1; dataOkMan = 1'b0; out_ready = 1'b0; ifu_valid = 1'b1;
    doReset();
    repeat (4) step();
    busZero = 1'b0; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    #1;
    checks++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0010) begin failures++; $display("[TB] FAIL rb_issue got=%0b/%h exp=1/80000010", ireq_valid, ireq_addr); end
    step();
    checks++; if (out_count !== 3'd3) begin failures++; $display("[TB] FAIL rb_count got=%0d exp=3", out_count); end
    redirect_valid = 1'b1; pc_target = 64'h8000_1000;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL rb_outvalid got=%0b exp=0", out_valid); end
    step();
    redirect_valid = 1'b0;
    #1;
    checks++; if (out_count !== 3'd0) begin failures++; $display("[TB] FAIL rb_flush got=%0d exp=0", out_count); end
    checks++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0010) begin failures++; $display("[TB] FAIL rb_drop_hold got=%0b/%h exp=1/80000010", ireq_valid, ireq_addr); end
    step();
    checks++; if (ireq_addr !== 64'h8000_0010) begin failures++; $display("[TB] FAIL rb_drop_hold2 got=%h exp=80000010", ireq_addr); end
    dataOkMan = 1'b1;
    step();
    dataOkMan = 1'b0;
    #1;
    checks++; if (out_count !== 3'd0) begin failures++; $display("[TB] FAIL rb_discard got=%0d exp=0", out_count); end
    checks++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_1000) begin failures++; $display("[TB] FAIL rb_target got=%0b/%h exp=1/80001000", ireq_valid, ireq_addr); end
    busZero = 1'b1;
    step();
    checks++; if (out_valid !== 1'b1 || out_pc !== 64'h8000_1000) begin failures++; $display("[TB] FAIL rb_first_pc got=%0b/%h exp=1/80001000", out_valid, out_pc); end
    checks++; if (out_instr !== 32'h8000_1000) begin failures++; $display("[TB] FAIL rb_first_instr got=%h exp=80001000", out_instr); end
  endtask

  task automatic test_redirect_pop();
    busZero = 1'b1; dataOkMan = 1'b0; out_ready = 1'b0; ifu_valid = 1'b1;
    doReset();
    step();
    step();
    busZero = 1'b0;
    step();
    checks++; if (out_count !== 3'd2 || ireq_addr !== 64'h8000_0008) begin failures++; $display("[TB] FAIL rp_setup got=%0d/%h exp=2/80000008", out_count, ireq_addr); end
    redirect_valid = 1'b1; pc_target = 64'h8000_2000; dataOkMan = 1'b1; out_ready = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL rp_outvalid got=%0b exp=0", out_valid); end
    step();
    redirect_valid = 1'b0; dataOkMan = 1'b0; out_ready = 1'b0;
    #1;
    checks++; if (out_count !== 3'd0) begin failures++; $display("[TB] FAIL rp_count got=%0d exp=0", out_count); end
    checks++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_2000) begin failures++; $display("[TB] FAIL rp_target got=%0b/%h exp=1/80002000", ireq_valid, ireq_addr); end
  endtask

  task automatic test_async_reset();
    busZero = 1'b1; dataOkMan = 1'b0; out_ready = 1'b0; ifu_valid = 1'b1;
    doReset();
    step();
    busZero = 1'b0;
    step();
    checks++; if (out_count !== 3'd1 || ireq_addr !== 64'h8000_0004) begin failures++; $display("[TB] FAIL ar_setup got=%0d/%h exp=1/80000004", out_count, ireq_addr); end
    rst = 1'b1;
    #1;
    checks++; if (out_count !== 3'd0 || out_valid !== 1'b0) begin failures++; $display("[TB] FAIL ar_queue got=%0d/%0b exp=0/0", out_count, out_valid); end
    checks++; if (out_pc !== 64'h0 || out_instr !== 32'h0) begin failures++; $display("[TB] FAIL ar_head got=%h/%h exp=0/0", out_pc, out_instr); end
    checks++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0000) begin failures++; $display("[TB] FAIL ar_req got=%0b/%h exp=1/80000000", ireq_valid, ireq_addr); end
    @(posedge clk); #1;
    rst = 1'b0; busZero = 1'b1;
    step();
    checks++; if (out_valid !== 1'b1 || out_pc !== 64'h8000_0000) begin failures++; $display("[TB] FAIL ar_restart got=%0b/%h exp=1/80000000", out_valid, out_pc); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset_stream();
    test_full_stall();
    test_wait_state();
    test_redirect_busy();
    test_redirect_pop();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
